// File: rtl/lsu.sv
// Memory-stage load/store unit on a req/gnt/rvalid bus; stalls IF/ID/EX from acceptance until the response (>=3 cycles, +1 per wait).
// Build option LSU_MISALIGN_EXC_EN: misaligned half/word accesses skip the bus and pulse misalign instead.
module lsu #(
  parameter int unsigned RESP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_rmem,
  input  logic        EX_wmem,
  input  logic [1:0]  EX_mem_type,
  input  logic        EX_mem_sign,
  input  logic [31:0] EX_result,
  input  logic [31:0] EX_FD_rs2_data,
  output logic        lsu_stall,
  output logic [31:0] MEM_load_data,
  output logic        MEM_load_valid,
  output logic        bus_err,
`ifdef LSU_MISALIGN_EXC_EN
  output logic        misalign,
`endif
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  output logic [3:0]  dbus_be,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  type_q, type_d;
  logic        sign_q, sign_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] ldata_q, ldata_d;
  logic        mis_q, mis_d;

  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;
  logic [31:0] shifted;
  logic [31:0] extracted;
  logic        timeout_hit;
  logic        misaligned_req;

  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = EX_FD_rs2_data;
    case (EX_mem_type)
      2'b00: begin
        fmt_be    = 4'b0001 << EX_result[1:0];
        fmt_wdata = {4{EX_FD_rs2_data[7:0]}};
      end
      2'b01: begin
        fmt_be    = EX_result[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{EX_FD_rs2_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = dbus_rdata;
    extracted = dbus_rdata;
    case (type_q)
      2'b00: begin
        shifted   = dbus_rdata >> {addr_q[1:0], 3'b000};
        extracted = {{24{sign_q & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        shifted   = dbus_rdata >> {addr_q[1], 4'b0000};
        extracted = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_EXC_EN
  assign misaligned_req = ((EX_mem_type == 2'b01) && EX_result[0]) ||
                          (EX_mem_type[1] && (EX_result[1:0] != 2'b00));
`else
  assign misaligned_req = 1'b0;
`endif

  // Counter holds completed WAIT cycles, so WAIT lasts at most RESP_TIMEOUT cycles.
  assign timeout_hit = (RESP_TIMEOUT != 0) && ((cnt_q + 32'd1) == RESP_TIMEOUT);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    type_d    = type_q;
    sign_d    = sign_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ldata_d   = ldata_q;
    mis_d     = mis_q;
    lsu_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (EX_rmem || EX_wmem) begin
          lsu_stall = 1'b1;
          addr_d    = EX_result;
          type_d    = EX_mem_type;
          sign_d    = EX_mem_sign;
          we_d      = EX_wmem;
          wdata_d   = fmt_wdata;
          be_d      = fmt_be;
          cnt_d     = 32'd0;
          err_d     = 1'b0;
          mis_d     = misaligned_req;
          state_d   = misaligned_req ? DONE : REQ;
        end
      end
      REQ: begin
        lsu_stall = 1'b1;
        if (dbus_gnt) begin
          cnt_d   = 32'd0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        lsu_stall = 1'b1;
        if (dbus_rvalid) begin
          if (!we_q) ldata_d = extracted;
          state_d = DONE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      // EX still shows the finished instruction here, so nothing is accepted.
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      type_q  <= 2'd0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      cnt_q   <= 32'd0;
      err_q   <= 1'b0;
      ldata_q <= 32'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      sign_q  <= sign_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ldata_q <= ldata_d;
      mis_q   <= mis_d;
    end
  end

  assign dbus_req       = (state_q == REQ);
  assign dbus_we        = we_q;
  assign dbus_addr      = {addr_q[31:2], 2'b00};
  assign dbus_wdata     = wdata_q;
  assign dbus_be        = be_q;
  assign MEM_load_data  = ldata_q;
  assign MEM_load_valid = (state_q == DONE) && !we_q && !err_q && !mis_q;
  assign bus_err        = (state_q == DONE) && err_q;
`ifdef LSU_MISALIGN_EXC_EN
  assign misalign       = (state_q == DONE) && mis_q;
`endif

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: schedule-based reference model compared every cycle, plus literal spot checks.
module tb_lsu;
  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        EX_rmem, EX_wmem, EX_mem_sign;
  logic [1:0]  EX_mem_type;
  logic [31:0] EX_result, EX_FD_rs2_data;
  logic        lsu_stall, MEM_load_valid, bus_err;
  logic [31:0] MEM_load_data;
`ifdef LSU_MISALIGN_EXC_EN
  logic        misalign;
`endif
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;

  lsu #(.RESP_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .EX_rmem(EX_rmem), .EX_wmem(EX_wmem), .EX_mem_type(EX_mem_type),
    .EX_mem_sign(EX_mem_sign), .EX_result(EX_result), .EX_FD_rs2_data(EX_FD_rs2_data),
    .lsu_stall(lsu_stall), .MEM_load_data(MEM_load_data),
    .MEM_load_valid(MEM_load_valid), .bus_err(bus_err),
`ifdef LSU_MISALIGN_EXC_EN
    .misalign(misalign),
`endif
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_be(dbus_be), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        chk_en;
  logic        exp_stall, exp_req, exp_valid, exp_err, exp_mis, exp_we;
  logic [31:0] exp_ldata, exp_addr, exp_wdata;
  logic [3:0]  exp_be;

  typedef struct {
    string       nm;
    logic [31:0] act;
    logic [31:0] exp;
  } lit_t;
  lit_t lq[$];

  int          obs_stall;
  logic        obs_got;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    lit_t e;
    if (chk_en) begin
      cmp("lsu_stall", {31'd0, lsu_stall}, {31'd0, exp_stall});
      cmp("dbus_req", {31'd0, dbus_req}, {31'd0, exp_req});
      cmp("MEM_load_valid", {31'd0, MEM_load_valid}, {31'd0, exp_valid});
      cmp("bus_err", {31'd0, bus_err}, {31'd0, exp_err});
      cmp("MEM_load_data", MEM_load_data, exp_ldata);
`ifdef LSU_MISALIGN_EXC_EN
      cmp("misalign", {31'd0, misalign}, {31'd0, exp_mis});
`endif
      if (exp_req) begin
        cmp("dbus_addr", dbus_addr, exp_addr);
        cmp("dbus_be", {28'd0, dbus_be}, {28'd0, exp_be});
        cmp("dbus_wdata", dbus_wdata, exp_wdata);
        cmp("dbus_we", {31'd0, dbus_we}, {31'd0, exp_we});
      end
    end
    while (lq.size() > 0) begin
      e = lq.pop_front();
      cmp(e.nm, e.act, e.exp);
    end
  end

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    lit_t t;
    t.nm = nm; t.act = a; t.exp = e;
    lq.push_back(t);
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_req = 1'b0; exp_valid = 1'b0; exp_err = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic idle(input logic rv);
    EX_rmem = 1'b0; EX_wmem = 1'b0; dbus_gnt = 1'b0; dbus_rvalid = rv;
    dbus_rdata = 32'hBAD0_BAD0; rst = 1'b0;
    set_idle_exp();
    @(posedge clk); #1;
  endtask

  // One access from acceptance (k=0) through DONE; the bus answers after the given delays.
  task automatic access(input logic ld, input logic st, input logic [1:0] ty, input logic sg,
                        input logic [31:0] ad, input logic [31:0] wd, input int gd, input int rd,
                        input logic no_rsp, input logic [31:0] rdat, input logic noise, input int rst_k);
    int tg, tr, td;
    logic mis, tmo, is_load;
    logic [31:0] v, newval;
    mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    mis = (ty == 2'd1 && ad[0]) || (ty >= 2'd2 && (ad % 4) != 0);
`endif
    is_load = !st;
    tmo = 1'b0;
    if (mis) begin
      tg = 0; tr = 0;
    end else begin
      tg = 1 + gd;
      if (no_rsp) begin tr = tg + TO; tmo = 1'b1; end
      else tr = tg + 1 + rd;
    end
    td = tr + 1;
    if (ty == 2'd0) begin
      v = (rdat >> (8 * (ad % 4))) & 32'hFF;
      newval = (sg && v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
      exp_be = 4'(1 << (ad % 4));
      exp_wdata = (wd & 32'hFF) * 32'h0101_0101;
    end else if (ty == 2'd1) begin
      v = (rdat >> (8 * (ad & 2))) & 32'hFFFF;
      newval = (sg && v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
      exp_be = ((ad & 2) != 0) ? 4'hC : 4'h3;
      exp_wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    end else begin
      newval = rdat;
      exp_be = 4'hF;
      exp_wdata = wd;
    end
    exp_addr = ad & ~32'd3;
    exp_we = st;
    obs_stall = 0; obs_got = 1'b0;
    for (int k = 0; k <= td; k++) begin
      EX_rmem = ld; EX_wmem = st; EX_mem_type = ty; EX_mem_sign = sg;
      EX_result = ad; EX_FD_rs2_data = wd;
      dbus_gnt = !mis && (k == tg);
      dbus_rvalid = (!mis && !tmo && k == tr) || (noise && k >= 1 && k <= tg);
      dbus_rdata = (noise && k >= 1 && k <= tg) ? ~rdat : rdat;
      rst = (k == rst_k);
      exp_stall = (k <= tr);
      exp_req = (k >= 1 && k <= tg);
      exp_valid = (k == td) && is_load && !tmo && !mis;
      exp_err = (k == td) && tmo;
      exp_mis = (k == td) && mis;
      if (k == td && is_load && !tmo && !mis) exp_ldata = newval;
      #1;
      if (lsu_stall) obs_stall++;
      if (dbus_req && !obs_got) begin
        obs_got = 1'b1; obs_addr = dbus_addr; obs_be = dbus_be;
        obs_wdata = dbus_wdata; obs_we = dbus_we;
      end
      @(posedge clk); #1;
      if (k == rst_k) break;
    end
  endtask

  initial begin
    chk_en = 1'b0; rst = 1'b1;
    EX_rmem = 1'b0; EX_wmem = 1'b0; EX_mem_type = 2'd0; EX_mem_sign = 1'b0;
    EX_result = 32'd0; EX_FD_rs2_data = 32'd0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'd0;
    set_idle_exp(); exp_ldata = 32'd0;
    exp_addr = 32'd0; exp_be = 4'd0; exp_wdata = 32'd0; exp_we = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    lit("reset_addr", dbus_addr, 32'd0);
    lit("reset_be", {28'd0, dbus_be}, 32'd0);
    lit("reset_ldata", MEM_load_data, 32'd0);
    rst = 1'b0;
    idle(1'b0);

    access(1, 0, 2'd0, 1, 32'h103, 32'd0, 0, 0, 0, 32'h80AA_BBCC, 0, -1);
    lit("sbyte_ldata", MEM_load_data, 32'hFFFF_FF80);
    lit("sbyte_addr", obs_addr, 32'h100);
    lit("sbyte_be", {28'd0, obs_be}, 32'h8);
    lit("sbyte_stall", obs_stall, 32'd3);

    access(1, 0, 2'd1, 0, 32'h202, 32'd0, 2, 2, 0, 32'h1234_5678, 1, -1);
    lit("uhalf_ldata", MEM_load_data, 32'h0000_1234);
    lit("uhalf_be", {28'd0, obs_be}, 32'hC);
    lit("uhalf_stall", obs_stall, 32'd7);

    access(0, 1, 2'd0, 0, 32'h301, 32'hDEAD_BEEF, 0, 1, 0, 32'd0, 0, -1);
    lit("sb_we", {31'd0, obs_we}, 32'd1);
    lit("sb_be", {28'd0, obs_be}, 32'h2);
    lit("sb_wdata", obs_wdata, 32'hEFEF_EFEF);
    lit("sb_ldata_held", MEM_load_data, 32'h0000_1234);

    access(1, 1, 2'd1, 0, 32'h202, 32'h1234_5678, 1, 0, 0, 32'hFFFF_FFFF, 0, -1);
    lit("sh_wdata", obs_wdata, 32'h5678_5678);
    idle(1'b0);

    access(1, 0, 2'd1, 1, 32'h200, 32'd0, 0, 1, 0, 32'h5A5A_8001, 0, -1);
    lit("shalf_ldata", MEM_load_data, 32'hFFFF_8001);
    access(1, 0, 2'd0, 0, 32'h102, 32'd0, 1, 0, 0, 32'h00AB_0000, 0, -1);
    lit("ubyte_ldata", MEM_load_data, 32'h0000_00AB);
    access(1, 0, 2'd3, 1, 32'h108, 32'd0, 0, 0, 0, 32'h8765_4321, 0, -1);
    lit("type3_ldata", MEM_load_data, 32'h8765_4321);

    access(1, 0, 2'd2, 0, 32'h500, 32'd0, 0, 0, 1, 32'h0, 0, -1);
    lit("tmo_stall", obs_stall, 32'd6);
    idle(1'b1);
    lit("tmo_ldata_held", MEM_load_data, 32'h8765_4321);
    idle(1'b0);

    access(1, 0, 2'd2, 0, 32'h401, 32'd0, 0, 0, 0, 32'hCAFE_F00D, 0, -1);
`ifdef LSU_MISALIGN_EXC_EN
    lit("mis_stall", obs_stall, 32'd1);
    lit("mis_ldata", MEM_load_data, 32'h8765_4321);
`else
    lit("mis_addr", obs_addr, 32'h400);
    lit("mis_be", {28'd0, obs_be}, 32'hF);
    lit("mis_ldata", MEM_load_data, 32'hCAFE_F00D);
`endif
    idle(1'b0);

    access(1, 0, 2'd2, 0, 32'h600, 32'd0, 0, 3, 0, 32'h1111_1111, 0, 3);
    EX_rmem = 1'b0; EX_wmem = 1'b0; rst = 1'b0; dbus_gnt = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h1111_1111;
    set_idle_exp(); exp_ldata = 32'd0;
    lit("rst_addr", dbus_addr, 32'd0);
    lit("rst_be", {28'd0, dbus_be}, 32'd0);
    lit("rst_wdata", dbus_wdata, 32'd0);
    lit("rst_we", {31'd0, dbus_we}, 32'd0);
    @(posedge clk); #1;
    idle(1'b0);

    access(1, 0, 2'd0, 1, 32'h7FE, 32'd0, 0, 0, 0, 32'h0045_0000, 0, -1);
    lit("recover_ldata", MEM_load_data, 32'h0000_0045);
    idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit forming the memory stage of the pipeline. It accepts the memory request produced by execute: address in `EX_result`, store data in `EX_FD_rs2_data`, read/write enables, type and sign. It drives a valid/grant/response data bus, stalls the pipeline for the duration of the access, and returns aligned, extended load data for writeback.

## Interface
- `RESP_TIMEOUT`, default 255: maximum WAIT cycles before the access is abandoned with `bus_err`; 0 disables the timeout.

- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `EX_rmem` in 1: load request.
- `EX_wmem` in 1: store request; if both are set, the access is treated as a store.
- `EX_mem_type` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `EX_mem_sign` in 1: 1 = sign-extend loads, 0 = zero-extend.
- `EX_result` in 32: byte address.
- `EX_FD_rs2_data` in 32: store data.
- `lsu_stall` out 1: holds the IF/ID/EX pipeline.
- `MEM_load_data` out 32: extended load result.
- `MEM_load_valid` out 1: one-cycle pulse when the load completes.
- `bus_err` out 1: one-cycle pulse when the timeout fires.
- `misalign` out 1: one-cycle pulse on a misaligned access; present only with the macro.
- `dbus_req` out 1, `dbus_we` out 1, `dbus_addr` out 32, `dbus_wdata` out 32, `dbus_be` out 4: request channel.
- `dbus_gnt` in 1: request accepted.
- `dbus_rvalid` in 1: response or write acknowledge.
- `dbus_rdata` in 32: read data.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- **IDLE**
  - `EX_rmem|EX_wmem` causes the LSU to register address, type, sign, we and formatted wdata/be, then go to REQ.
  - `lsu_stall` is asserted combinationally in this cycle.
  - Without a request, stay in IDLE with `lsu_stall=0`.
- **REQ**
  - `dbus_req=1`; addr/we/wdata/be are held from registers.
  - On `dbus_gnt`, go to WAIT and deassert `dbus_req` next cycle.
  - `dbus_rvalid` is ignored in this state.
- **WAIT**
  - On `dbus_rvalid`: capture the extracted load data (loads only), then go to DONE.
  - Cycle counter: if it reaches `RESP_TIMEOUT` (when nonzero) with no response, go to DONE with `bus_err` set.
- **DONE**
  - `lsu_stall=0`.
  - `MEM_load_valid=1` for loads (not on error).
  - `bus_err` pulses if set.
  - Go unconditionally to IDLE. EX still presents the same instruction in this cycle, so it must not be re-accepted.
- Address and byte enables:
  - `dbus_addr = {addr[31:2],2'b00}`.
  - Byte: `be = 4'b0001 << addr[1:0]`, `wdata = {4{rs2[7:0]}}`.
  - Half: `be = addr[1] ? 4'b1100 : 4'b0011`, `wdata = {2{rs2[15:0]}}`.
  - Word: `be = 4'b1111`, `wdata = rs2`.
  - `dbus_be` is driven for loads too.
- Load extract: `rdata >> (8*addr[1:0])` (half uses `addr[1]`), then sign- or zero-extend from bit 7 or 15. Word loads are unmodified.
- `MEM_load_data` holds its value until the next load completes.
- Reset:
  - All outputs go to 0, state to IDLE, counter to 0.
  - A reset in any state abandons the access; `dbus_req` is low the cycle after reset is sampled.
  - A late `dbus_rvalid` arriving in IDLE or REQ is ignored.

## Timing
- Acceptance cycle is T0 (IDLE, stall=1).
- T1: REQ with `dbus_req=1`.
- `dbus_gnt` at T1 and `dbus_rvalid` at T2 give DONE at T3, so minimum stall is 3 cycles (T0–T2).
- Each cycle of grant delay or response delay adds one stall cycle.
- `MEM_load_data` is registered: it is valid in DONE and thereafter.
- `dbus_*` outputs are registered or state-decoded, with no combinational path from `dbus_gnt`/`dbus_rvalid` to `dbus_req`.
- `lsu_stall` is combinational from `EX_rmem`, `EX_wmem` and state only.
- Back-to-back accesses: DONE→IDLE, then the next request is accepted in the following cycle. There is one idle bus cycle minimum between accesses.

## Configuration
- `LSU_MISALIGN_EXC_EN` defined:
  - A half access with `addr[0]=1` or a word access with `addr[1:0]!=0` goes IDLE→DONE directly, with no bus request.
  - `misalign` pulses in DONE; `MEM_load_valid=0`; `MEM_load_data` is unchanged.
  - Stall lasts exactly 1 cycle (T0).
- Not defined:
  - The `misalign` port is absent.
  - Misaligned offset bits below the access size are ignored: half uses `addr[1]` only, word is aligned down. The access proceeds normally.

## Test plan
- Signed byte load: addr 0x103, type 00, sign 1, `gnt` at T1, `rvalid` at T2 with rdata 0x80AA_BBCC -> `dbus_addr` 0x100, be 1000, DONE at T3, `MEM_load_data` 0xFFFF_FF80, stall high T0–T2 only.
- Unsigned half load with delays: addr 0x202, type 01, sign 0, `gnt` at T3, `rvalid` at T6 with 0x1234_5678 -> be 1100, `MEM_load_data` 0x0000_1234, stall T0–T6.
- Byte store: addr 0x301, rs2 0xDEAD_BEEF, type 00 -> `dbus_we` 1, be 0010, wdata 0xEFEF_EFEF; ack `rvalid` -> DONE with `MEM_load_valid` 0.
- Timeout: `RESP_TIMEOUT`=4, word load granted, no `rvalid` -> `bus_err` pulses in DONE; a late `rvalid` in IDLE is ignored.
- Reset mid-WAIT: assert `rst` for 1 cycle -> all outputs 0, state IDLE; a following `rvalid` has no effect.
- Misaligned word load at 0x401:
  - With the macro: no `dbus_req`, `misalign` pulse, 1-cycle stall.
  - Without the macro: `dbus_addr` 0x400, be 1111.
